// File: rtl/nn_frame_sequencer_if.sv
// Byte-stream handshake bundle shared by the frame sequencer and its neighbours:
// an upstream byte stream (s_*) and a downstream result stream (m_*).
interface nn_frame_sequencer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/nn_frame_sequencer.sv
// Loads one frame (parameters, inputs) into the neural network core, runs it and streams
// the neuron results out. Optional trailing checksum byte: define NN_FRAME_CHECKSUM_EN.
module nn_frame_sequencer #(
    parameter int N_PARAM    = 24,
    parameter int N_INPUT    = 4,
    parameter int RUN_CYCLES = 2,
    parameter int N_OUT      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    nn_frame_sequencer_if.slave   bus,
    output logic [7:0]            nn_data_in,
    output logic                  nn_changes,
    output logic [1:0]            nn_sel_out,
    input  logic [7:0]            nn_out,
    output logic                  busy
`ifdef NN_FRAME_CHECKSUM_EN
    ,
    output logic                  chk_err
`endif
);

    localparam int CNT_W = $clog2(N_PARAM + N_INPUT + 2);
    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES + 1) : 1;

    typedef enum logic [3:0] {
        ST_PARAM,
        ST_ADV1,
        ST_INPUT,
        ST_ADV2,
        ST_RUN,
        ST_ADV3,
        ST_SEL,
        ST_OUT,
        ST_ADV4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [RUN_W-1:0]   run_cnt, run_cnt_nxt;
    logic [1:0]         out_idx, out_idx_nxt;
    logic [7:0]         data_nxt;
    logic [7:0]         m_data_nxt;
    logic               m_valid_nxt;
    logic               m_last_nxt;
    logic               s_ready_nxt;
    logic               changes_nxt;
    logic               busy_nxt;
    logic               accept;
`ifdef NN_FRAME_CHECKSUM_EN
    logic [7:0]         sum, sum_nxt;
    logic               chk_err_nxt;
`endif

    assign accept = bus.s_valid && bus.s_ready;

    // Every output is a register; the comb process decides its value for the next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_PARAM;
            byte_cnt    <= '0;
            run_cnt     <= '0;
            out_idx     <= '0;
            nn_data_in  <= '0;
            nn_changes  <= 1'b0;
            nn_sel_out  <= '0;
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
            busy        <= 1'b0;
`ifdef NN_FRAME_CHECKSUM_EN
            sum         <= '0;
            chk_err     <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            run_cnt     <= run_cnt_nxt;
            out_idx     <= out_idx_nxt;
            nn_data_in  <= data_nxt;
            nn_changes  <= changes_nxt;
            nn_sel_out  <= out_idx_nxt;
            bus.s_ready <= s_ready_nxt;
            bus.m_valid <= m_valid_nxt;
            bus.m_data  <= m_data_nxt;
            bus.m_last  <= m_last_nxt;
            busy        <= busy_nxt;
`ifdef NN_FRAME_CHECKSUM_EN
            sum         <= sum_nxt;
            chk_err     <= chk_err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        run_cnt_nxt  = run_cnt;
        out_idx_nxt  = out_idx;
        data_nxt     = nn_data_in;
        m_valid_nxt  = bus.m_valid;
        m_data_nxt   = bus.m_data;
        m_last_nxt   = bus.m_last;
`ifdef NN_FRAME_CHECKSUM_EN
        sum_nxt      = sum;
        chk_err_nxt  = chk_err;
`endif

        case (state)
            ST_PARAM: begin
                if (accept) begin
                    data_nxt = bus.s_data;
`ifdef NN_FRAME_CHECKSUM_EN
                    sum_nxt  = sum + bus.s_data;
`endif
                    if (byte_cnt == CNT_W'(N_PARAM - 1)) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = ST_ADV1;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
                end
            end
            ST_ADV1: state_nxt = ST_INPUT;
            ST_INPUT: begin
                if (accept) begin
`ifdef NN_FRAME_CHECKSUM_EN
                    // The trailing checksum byte is judged here and never reaches the core.
                    if (byte_cnt == CNT_W'(N_INPUT)) begin
                        chk_err_nxt  = (bus.s_data != sum);
                        sum_nxt      = '0;
                        byte_cnt_nxt = '0;
                        state_nxt    = ST_ADV2;
                    end else begin
                        data_nxt     = bus.s_data;
                        sum_nxt      = sum + bus.s_data;
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
`else
                    data_nxt = bus.s_data;
                    if (byte_cnt == CNT_W'(N_INPUT - 1)) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = ST_ADV2;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
`endif
                end
            end
            ST_ADV2: begin
                run_cnt_nxt = '0;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (run_cnt == RUN_W'(RUN_CYCLES - 1)) begin
                    run_cnt_nxt = '0;
                    state_nxt   = ST_ADV3;
                end else begin
                    run_cnt_nxt = run_cnt + 1'b1;
                end
            end
            ST_ADV3: state_nxt = ST_SEL;
            ST_SEL: begin
                m_data_nxt  = nn_out;
                m_valid_nxt = 1'b1;
                m_last_nxt  = (out_idx == 2'(N_OUT - 1));
                state_nxt   = ST_OUT;
            end
            ST_OUT: begin
                if (bus.m_valid && bus.m_ready) begin
                    m_valid_nxt = 1'b0;
                    m_last_nxt  = 1'b0;
                    if (out_idx == 2'(N_OUT - 1)) begin
                        out_idx_nxt = '0;
                        state_nxt   = ST_ADV4;
                    end else begin
                        out_idx_nxt = out_idx + 2'd1;
                        state_nxt   = ST_SEL;
                    end
                end
            end
            ST_ADV4: state_nxt = ST_PARAM;
            default: state_nxt = ST_PARAM;
        endcase

        // Handshake, pulse and busy flags follow the state being entered so they line up with it.
        s_ready_nxt = (state_nxt == ST_PARAM) || (state_nxt == ST_INPUT);
        changes_nxt = (state_nxt == ST_ADV1) || (state_nxt == ST_ADV2) ||
                      (state_nxt == ST_ADV3) || (state_nxt == ST_ADV4);
        busy_nxt    = !((state_nxt == ST_PARAM) && (byte_cnt_nxt == '0));
    end

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Directed self-checking bench for nn_frame_sequencer with a simple core model
// (nn_out = 0x10 + nn_sel_out). Covers the checksum option when NN_FRAME_CHECKSUM_EN is defined.
module tb_nn_frame_sequencer;

`ifdef NN_FRAME_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic [7:0] nn_data_in;
    logic       nn_changes;
    logic [1:0] nn_sel_out;
    logic [7:0] nn_out;
    logic       busy;
`ifdef NN_FRAME_CHECKSUM_EN
    logic       chk_err;
`endif

    int         checks;
    int         errors;
    int         pulse_total;
    int         pulse_base;
    logic [7:0] frame_sum;

    nn_frame_sequencer_if bus ();

    nn_frame_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .nn_data_in (nn_data_in),
        .nn_changes (nn_changes),
        .nn_sel_out (nn_sel_out),
        .nn_out     (nn_out),
        .busy       (busy)
`ifdef NN_FRAME_CHECKSUM_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    assign nn_out = 8'h10 + {6'b0, nn_sel_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pulse_total = 0;
    always @(negedge clk) begin
        if (nn_changes) pulse_total = pulse_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte, wait for acceptance, then check the core-side outputs one cycle later.
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] exp_data,
                                 input logic exp_pulse, input string tag);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) checkOutput({tag, "_accept_timeout"}, {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_data_in"}, {24'd0, nn_data_in}, {24'd0, exp_data});
        checkOutput({tag, "_changes"}, {31'd0, nn_changes}, {31'd0, exp_pulse});
    endtask

    task automatic sendParams(input logic [7:0] base);
        logic [7:0] b;
        pulse_base = pulse_total;
        frame_sum  = 8'h00;
        for (int k = 0; k < 24; k++) begin
            b = base + 8'(k);
            frame_sum = frame_sum + b;
            applyStimulus(b, b, (k == 23), "param");
        end
    endtask

    task automatic sendInputs(input logic [7:0] base, input logic corrupt);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = base + 8'(k);
            frame_sum = frame_sum + b;
            applyStimulus(b, b, (k == 3) && !CHK, "input");
        end
`ifdef NN_FRAME_CHECKSUM_EN
        applyStimulus(frame_sum ^ {7'd0, corrupt}, base + 8'd3, 1'b1, "chk_byte");
        checkOutput("chk_err", {31'd0, chk_err}, {31'd0, corrupt});
`else
        if (corrupt) b = 8'h00;
`endif
    endtask

    // Read the four results; optionally hold m_ready low for 10 cycles on the first one.
    task automatic readFrame(input logic stall);
        int n;
        if (stall) bus.m_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (!bus.m_valid && n < 64) begin
                @(negedge clk);
                n++;
            end
            checkOutput("result_valid", {31'd0, bus.m_valid}, 32'd1);
            checkOutput("result_latency", n, (r == 0) ? 32'd5 : 32'd2);
            checkOutput("result_data", {24'd0, bus.m_data}, 32'h10 + r);
            checkOutput("result_last", {31'd0, bus.m_last}, {31'd0, (r == 3)});
            checkOutput("result_sel", {30'd0, nn_sel_out}, r);
            if (stall && r == 0) begin
                repeat (10) begin
                    @(negedge clk);
                    checkOutput("stall_valid", {31'd0, bus.m_valid}, 32'd1);
                    checkOutput("stall_data", {24'd0, bus.m_data}, 32'h10);
                    checkOutput("stall_last", {31'd0, bus.m_last}, 32'd0);
                    checkOutput("stall_sel", {30'd0, nn_sel_out}, 32'd0);
                    checkOutput("stall_changes", {31'd0, nn_changes}, 32'd0);
                end
                checkOutput("stall_pulses", pulse_total - pulse_base, 32'd3);
                bus.m_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("adv4_valid", {31'd0, bus.m_valid}, 32'd0);
        checkOutput("adv4_changes", {31'd0, nn_changes}, 32'd1);
        @(negedge clk);
        checkOutput("frame_pulses", pulse_total - pulse_base, 32'd4);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_s_ready", {31'd0, bus.s_ready}, 32'd1);
        checkOutput("idle_sel", {30'd0, nn_sel_out}, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
        checkOutput({tag, "_data_in"}, {24'd0, nn_data_in}, 32'd0);
        checkOutput({tag, "_changes"}, {31'd0, nn_changes}, 32'd0);
        checkOutput({tag, "_sel"}, {30'd0, nn_sel_out}, 32'd0);
        checkOutput({tag, "_m_valid"}, {31'd0, bus.m_valid}, 32'd0);
        checkOutput({tag, "_m_data"}, {24'd0, bus.m_data}, 32'd0);
        checkOutput({tag, "_m_last"}, {31'd0, bus.m_last}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef NN_FRAME_CHECKSUM_EN
        checkOutput({tag, "_chk_err"}, {31'd0, chk_err}, 32'd0);
`endif
    endtask

    initial begin
        int acc;
        checks      = 0;
        errors      = 0;
        pulse_base  = 0;
        frame_sum   = 8'h00;
        rstn        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstn = 1'b1;

        $display("[TB] frame 1: back-to-back bytes 0x01..0x1C");
        sendParams(8'h01);
        sendInputs(8'h19, 1'b0);
        readFrame(1'b0);

        $display("[TB] frame 2: same bytes, result backpressure");
        sendParams(8'h01);
        sendInputs(8'h19, 1'b1);
        readFrame(1'b1);

        $display("[TB] frame 3: s_valid toggled during PARAM");
        pulse_base = pulse_total;
        frame_sum  = 8'h00;
        acc        = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            #1;
            bus.s_valid = (i % 2 == 0);
            bus.s_data  = 8'h21 + 8'(i / 2);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin
                acc++;
                frame_sum = frame_sum + bus.s_data;
            end
            checkOutput("toggle_changes", {31'd0, nn_changes}, {31'd0, (i == 47)});
        end
        bus.s_valid = 1'b0;
        checkOutput("toggle_accepts", acc, 32'd24);
        checkOutput("toggle_data_in", {24'd0, nn_data_in}, 32'h38);
        sendInputs(8'h41, 1'b0);
        readFrame(1'b0);

        $display("[TB] frame 4: reset during RUN");
        sendParams(8'h51);
        sendInputs(8'h71, 1'b1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkResetValues("midrun");
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] frame 5: fresh frame after reset");
        sendParams(8'h81);
        sendInputs(8'hA1, 1'b0);
        readFrame(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule

// File: doc/nn_frame_sequencer.md
Name: nn_frame_sequencer

Overview:
- Sits directly upstream and downstream of the neural network core; it is the core's only driver.
- Accepts a byte stream over a valid/ready handshake. Drives the core's data_in, changes and selector_output so that one frame is loaded and evaluated: parameters, then inputs, then run.
- Reads the four neuron results back and emits them on a valid/ready output stream.
- Issues exactly four changes pulses per frame, so the core's 2-bit phase counter wraps back into lock-step with this block.

Parameters:
- N_PARAM, 24, parameter bytes per frame (4 neurons x {w0,w1,w2,w3,bias,threshold})
- N_INPUT, 4, input bytes per frame
- RUN_CYCLES, 2, cycles spent in the compute phase before readback (>=1)
- N_OUT, 4, result bytes read back per frame (<=4)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  upstream byte valid
- s_ready  out  1  block can accept a byte
- s_data  in  8  upstream byte
- nn_data_in  out  8  byte to core data_in
- nn_changes  out  1  one-cycle phase-advance pulse to core
- nn_sel_out  out  2  core selector_output
- nn_out  in  8  core network_outputs
- m_valid  out  1  result byte valid
- m_ready  in  1  downstream accepts result
- m_data  out  8  result byte
- m_last  out  1  marks final result of a frame
- busy  out  1  high in every state except PARAM with byte count 0

Behaviour:
- Reset (rstn low, async): state=PARAM, counters=0, s_ready=0, nn_data_in=0, nn_changes=0, nn_sel_out=0, m_valid=0, m_data=0, m_last=0, busy=0. Reset mid-frame abandons the frame. The core must share the same reset so both restart in phase 0.
- All outputs are registered.
- States: PARAM, ADV1, INPUT, ADV2, RUN, ADV3, SEL, OUT, ADV4.
- PARAM/INPUT:
  - s_ready=1.
  - Accept on s_valid&&s_ready. The registered byte appears on nn_data_in the next cycle and is held until the next accept.
  - Byte counter increments per accept.
  - Accepting byte N_PARAM-1 (resp. N_INPUT-1) moves to ADV1 (resp. ADV2) and clears the counter.
  - s_valid gaps are allowed; they stall the counter only.
- ADVn: s_ready=0. nn_changes=1 for exactly one cycle. Next state:
  - ADV1 -> INPUT
  - ADV2 -> RUN
  - ADV3 -> SEL
  - ADV4 -> PARAM
- RUN: s_ready=0. Wait RUN_CYCLES cycles, then ADV3.
- SEL:
  - nn_sel_out = out index (starts 0).
  - One settle cycle, then OUT. In OUT, m_data is captured from nn_out and m_valid=1.
- OUT:
  - m_valid, m_data and m_last hold stable until m_ready.
  - On handshake with index < N_OUT-1: index+1, go to SEL, m_valid=0.
  - On the handshake with index = N_OUT-1 (m_last=1): go to ADV4, index=0.
- m_ready backpressure is unbounded; no timeout.
- s_valid asserted outside PARAM/INPUT is ignored (s_ready=0); no byte is consumed.
- Total nn_changes pulses per completed frame = 4. The core phase wraps 3->0 on the ADV4 pulse.
- Frame latency from last input byte accepted to first m_valid = 1 (ADV2) + RUN_CYCLES + 1 (ADV3) + 1 (SEL) cycles.

Optional Feature:
- Macro: NN_FRAME_CHECKSUM_EN.
- Defined:
  - INPUT accepts N_INPUT+1 bytes. The extra byte is not forwarded to the core: nn_data_in holds the last input byte.
  - The checksum byte must equal the mod-256 sum of all N_PARAM+N_INPUT preceding frame bytes.
  - Adds output port chk_err (1 bit, reset 0). It is set at the ADV2 pulse when the byte mismatches, and cleared at the ADV2 pulse of a frame whose checksum matches.
  - The frame still runs and results are still emitted; the consumer qualifies them with chk_err.
- Undefined: INPUT accepts exactly N_INPUT bytes and port chk_err does not exist.

Test Plan:
- Reset then 28 back-to-back bytes (0x01..0x1C), m_ready=1 -> exactly one nn_changes pulse after byte 24 and one after byte 28. nn_data_in tracks each byte one cycle after accept.
- Core model returning nn_out = 0x10+nn_sel_out -> m_data sequence 0x10,0x11,0x12,0x13; m_last only on 0x13; 4 nn_changes pulses per frame; a second frame produces identical timing.
- s_valid toggled 1/0 every cycle during PARAM -> 24 accepts over 48 cycles; ADV1 occurs only after the 24th accept.
- m_ready held 0 for 10 cycles on the first result -> m_valid/m_data/m_last stable throughout; nn_sel_out unchanged; no extra nn_changes pulse.
- rstn pulsed low during RUN -> all outputs return to reset values asynchronously; next frame is accepted from byte 0 and produces 4 changes pulses.
- NN_FRAME_CHECKSUM_EN: a frame with a correct sum byte gives chk_err=0; a frame with the sum byte XOR 0x01 gives chk_err=1, results are still emitted, and a following good frame clears chk_err.
